uart_rx: RTL and testbench

Asynchronous 8N1 UART receiver, the receive-side counterpart of the car's UART transmitter and sharing its `CLK_FREQ`/`BAUD_RATE` parameterisation. It synchronises the raw RX pin, detects the start bit and samples each bit at mid-bit. It then presents the received byte to the bus peripheral through a valid/read handshake, with frame-error and overrun reporting.

---
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side handshake between the UART receiver and the bus peripheral.
// The receiver drives the data and status lines; the consumer drives rd_i.
interface uart_rx_if;
    logic       rd_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    modport slave  (input rd_i, output data_o, valid_o, frame_err_o, overrun_o, busy_o);
    modport master (output rd_i, input data_o, valid_o, frame_err_o, overrun_o, busy_o);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_pin, samples each bit at mid-bit and
// hands the byte over a valid/read handshake with frame-error and overrun pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx_pin,
    uart_rx_if.slave bus
);
    localparam int CNT_MAX = CLK_FREQ / BAUD_RATE;
    localparam int HALF    = CNT_MAX / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s, rx_d;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shifter, shifter_n;
    logic [7:0]  data_q, data_n;
    logic        valid_q, valid_n;
    logic        ferr_q, ferr_n;
    logic        ovr_q, ovr_n;

    // rx_d trails rx_s by one cycle so IDLE can spot the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_pin;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shifter <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shifter <= shifter_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            ovr_q   <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_idx_n = bit_idx;
        shifter_n = shifter;
        data_n    = data_q;
        valid_n   = valid_q & ~bus.rd_i;
        ferr_n    = 1'b0;
        ovr_n     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_d && !rx_s) state_n = START;
            end
            START: begin
                if (cnt == 16'(HALF - 1)) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n     = '0;
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == 16'(CNT_MAX - 1)) begin
                    cnt_n     = '0;
                    shifter_n = {rx_s, shifter[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == 16'(CNT_MAX - 1)) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        // a read in the load cycle consumes the old byte, so no overrun
                        data_n  = shifter;
                        valid_n = 1'b1;
                        ovr_n   = valid_q & ~bus.rd_i;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = ferr_q;
    assign bus.overrun_o   = ovr_q;
    assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (434 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BIT  = 434;
    localparam int FAST = 421;
    localparam int SLOW = 447;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_pin = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt = 0;
    int   lat;
    int   f0, o0;

    uart_rx_if bus ();
    uart_rx dut (.clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (bus.overrun_o)   ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc, input logic stop);
        @(posedge clk); #1 rx_pin = 1'b0;
        repeat (bc) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_pin = b[i];
            repeat (bc) @(posedge clk);
        end
        #1 rx_pin = stop;
        repeat (bc) @(posedge clk);
    endtask

    task automatic read_byte(input string tag);
        @(posedge clk); #1 bus.rd_i = 1'b1;
        @(posedge clk); #1 bus.rd_i = 1'b0;
        chk(tag, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        bus.rd_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  32'(bus.data_o), 32'h00);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_busy",  32'(bus.busy_o), 32'd0);
        chk("rst_ferr",  32'(bus.frame_err_o), 32'd0);
        chk("rst_ovr",   32'(bus.overrun_o), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // good byte, with stop-sample latency measured from the start edge
        f0 = ferr_cnt; o0 = ovr_cnt; lat = 0;
        fork
            send_frame(8'hA5, BIT, 1'b1);
            begin
                @(posedge clk);
                while (lat < 6000) begin
                    @(posedge clk); lat++;
                    #1 if (bus.valid_o) break;
                end
            end
        join
        chk("a5_latency", 32'(lat >= 4125 && lat <= 4127), 32'd1);
        chk("a5_data",  32'(bus.data_o), 32'hA5);
        chk("a5_valid", 32'(bus.valid_o), 32'd1);
        chk("a5_ferr",  32'(ferr_cnt - f0), 32'd0);
        chk("a5_ovr",   32'(ovr_cnt - o0), 32'd0);
        read_byte("a5_read");

        // glitch: short low pulse is a false start
        @(posedge clk); #1 rx_pin = 1'b0;
        repeat (50) @(posedge clk);
        #1 chk("glitch_busy", 32'(bus.busy_o), 32'd1);
        repeat (50) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (220) @(posedge clk);
        #1;
        chk("glitch_idle",  32'(bus.busy_o), 32'd0);
        chk("glitch_valid", 32'(bus.valid_o), 32'd0);
        chk("glitch_data",  32'(bus.data_o), 32'hA5);

        // frame error then break held low for 5 bit times
        f0 = ferr_cnt;
        send_frame(8'h00, BIT, 1'b0);
        repeat (5 * BIT) @(posedge clk);
        #1;
        chk("brk_busy",  32'(bus.busy_o), 32'd1);
        chk("brk_ferr",  32'(ferr_cnt - f0), 32'd1);
        chk("brk_valid", 32'(bus.valid_o), 32'd0);
        chk("brk_data",  32'(bus.data_o), 32'hA5);
        rx_pin = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("brk_exit", 32'(bus.busy_o), 32'd0);
        repeat (BIT) @(posedge clk);
        send_frame(8'h3C, BIT, 1'b1);
        chk("brk_3c_data",  32'(bus.data_o), 32'h3C);
        chk("brk_3c_valid", 32'(bus.valid_o), 32'd1);
        chk("brk_3c_ferr",  32'(ferr_cnt - f0), 32'd1);
        read_byte("brk_3c_read");

        // overrun: two back-to-back frames, nothing read
        o0 = ovr_cnt;
        send_frame(8'h55, BIT, 1'b1);
        send_frame(8'h3C, BIT, 1'b1);
        chk("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_data",  32'(bus.data_o), 32'h3C);
        chk("ovr_valid", 32'(bus.valid_o), 32'd1);

        // read exactly in the load cycle: no overrun, valid stays set
        o0 = ovr_cnt;
        fork
            send_frame(8'hC3, BIT, 1'b1);
            begin
                @(posedge clk);
                repeat (4125) @(posedge clk);
                #1 bus.rd_i = 1'b1;
                @(posedge clk);
                #1 bus.rd_i = 1'b0;
                chk("rdload_valid_now", 32'(bus.valid_o), 32'd1);
            end
        join
        chk("rdload_ovr",   32'(ovr_cnt - o0), 32'd0);
        chk("rdload_data",  32'(bus.data_o), 32'hC3);
        chk("rdload_valid", 32'(bus.valid_o), 32'd1);
        read_byte("rdload_read");

        // baud skew +/-3%
        f0 = ferr_cnt;
        send_frame(8'h96, FAST, 1'b1);
        chk("fast_data", 32'(bus.data_o), 32'h96);
        chk("fast_valid", 32'(bus.valid_o), 32'd1);
        read_byte("fast_read");
        send_frame(8'h69, SLOW, 1'b1);
        send_frame(8'h96, SLOW, 1'b1);
        chk("slow_data", 32'(bus.data_o), 32'h96);
        chk("skew_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("slow_valid", 32'(bus.valid_o), 32'd1);

        // reset during bit 4 of 0xF0 (bits 0..3 low, bit 4 high)
        f0 = ferr_cnt; o0 = ovr_cnt;
        @(posedge clk); #1 rx_pin = 1'b0;
        repeat (5 * BIT) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (200) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("mrst_data",  32'(bus.data_o), 32'h00);
        chk("mrst_valid", 32'(bus.valid_o), 32'd0);
        chk("mrst_busy",  32'(bus.busy_o), 32'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        chk("mrst_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
        send_frame(8'h81, BIT, 1'b1);
        chk("mrst_81_data",  32'(bus.data_o), 32'h81);
        chk("mrst_81_valid", 32'(bus.valid_o), 32'd1);
        chk("mrst_81_ovr",   32'(ovr_cnt - o0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
